// File: rtl/demux_2_32_buf.sv
// Buffered 1-to-2 demux: each accepted 32-bit word goes to channel A (in_sel=1) or B (in_sel=0),
// each channel with its own 2-entry FIFO. Define DEMUX_STATS_EN for per-channel pop counters.
module demux_2_32_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sel,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [31:0] a_data,
  output logic        b_valid,
  input  logic        b_ready,
  output logic [31:0] b_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0] a_count,
  output logic [15:0] b_count
`endif
);

  localparam int DATA_W = 32;
  localparam int CH_A   = 0;
  localparam int CH_B   = 1;

  logic [DATA_W-1:0] mem_p0 [2][2];
  logic [1:0]        occ_p0 [2];
  logic              wptr_p0 [2];
  logic              rptr_p0 [2];

  logic [1:0] vld_p0;
  logic [1:0] rdy;
  logic [1:0] push;
  logic [1:0] pop;

  // Acceptance looks only at occupancy, never at consumer ready, so a full
  // channel refuses a push even in a cycle where it also pops.
  assign in_ready     = in_sel ? (occ_p0[CH_A] != 2'd2) : (occ_p0[CH_B] != 2'd2);
  assign push[CH_A]   = in_valid & in_ready & in_sel;
  assign push[CH_B]   = in_valid & in_ready & ~in_sel;
  assign vld_p0[CH_A] = (occ_p0[CH_A] != 2'd0);
  assign vld_p0[CH_B] = (occ_p0[CH_B] != 2'd0);
  assign rdy[CH_A]    = a_ready;
  assign rdy[CH_B]    = b_ready;
  assign pop          = vld_p0 & rdy;

  // Stage p0: FIFO control state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        occ_p0[c]  <= 2'd0;
        wptr_p0[c] <= 1'b0;
        rptr_p0[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wptr_p0[c] <= ~wptr_p0[c];
        if (pop[c])  rptr_p0[c] <= ~rptr_p0[c];
        case ({push[c], pop[c]})
          2'b10:   occ_p0[c] <= occ_p0[c] + 2'd1;
          2'b01:   occ_p0[c] <= occ_p0[c] - 2'd1;
          default: occ_p0[c] <= occ_p0[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem_p0[c][wptr_p0[c]] <= in_data;
    end
  end

  assign a_valid = vld_p0[CH_A];
  assign b_valid = vld_p0[CH_B];
  assign a_data  = vld_p0[CH_A] ? mem_p0[CH_A][rptr_p0[CH_A]] : '0;
  assign b_data  = vld_p0[CH_B] ? mem_p0[CH_B][rptr_p0[CH_B]] : '0;

`ifdef DEMUX_STATS_EN
  logic [15:0] cnt_p0 [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0[CH_A] <= 16'h0;
      cnt_p0[CH_B] <= 16'h0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (pop[c]) cnt_p0[c] <= cnt_p0[c] + 16'h1;
      end
    end
  end

  assign a_count = cnt_p0[CH_A];
  assign b_count = cnt_p0[CH_B];
`endif

endmodule

// File: tb/tb_demux_2_32_buf.sv
// Directed self-checking bench for demux_2_32_buf; stats counters are exercised when
// DEMUX_STATS_EN is defined.
module tb_demux_2_32_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_data;
`ifdef DEMUX_STATS_EN
  logic [15:0] a_count;
  logic [15:0] b_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  demux_2_32_buf dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data)
`ifdef DEMUX_STATS_EN
    ,
    .a_count  (a_count),
    .b_count  (b_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one edge, then settle 1 time unit so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_a_valid", {31'h0, a_valid}, 32'h0);
    chk("rst_b_valid", {31'h0, b_valid}, 32'h0);
    chk("rst_a_data", a_data, 32'h0);
    chk("rst_b_data", b_data, 32'h0);
    in_sel = 1'b1; #1;
    chk("rst_in_ready_sel1", {31'h0, in_ready}, 32'h1);
    in_sel = 1'b0; #1;
    chk("rst_in_ready_sel0", {31'h0, in_ready}, 32'h1);

    // Single push to A
    a_ready = 1'b1;
    in_sel = 1'b1; in_data = 32'hDEADBEEF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_a_valid", {31'h0, a_valid}, 32'h1);
    chk("single_a_data", a_data, 32'hDEADBEEF);
    chk("single_b_valid", {31'h0, b_valid}, 32'h0);
    tick();
    chk("single_a_valid_gone", {31'h0, a_valid}, 32'h0);
    chk("single_a_data_zero", a_data, 32'h0);

    // Backpressure on B
    b_ready = 1'b0; in_sel = 1'b0;
    in_data = 32'h1; in_valid = 1'b1; #1;
    chk("bp_ready_w1", {31'h0, in_ready}, 32'h1);
    tick();
    in_data = 32'h2; #1;
    chk("bp_ready_w2", {31'h0, in_ready}, 32'h1);
    tick();
    in_data = 32'h3; #1;
    chk("bp_ready_w3", {31'h0, in_ready}, 32'h0);
    chk("bp_b_head", b_data, 32'h1);
    in_valid = 1'b0;

    // A still accepts while B is full
    in_sel = 1'b1; in_data = 32'hA5A5A5A5; in_valid = 1'b1; #1;
    chk("afree_in_ready", {31'h0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    chk("afree_a_valid", {31'h0, a_valid}, 32'h1);
    chk("afree_a_data", a_data, 32'hA5A5A5A5);
    chk("afree_b_data", b_data, 32'h1);
    in_sel = 1'b0; #1;
    chk("afree_b_still_full", {31'h0, in_ready}, 32'h0);
    tick();
    chk("afree_a_drained", {31'h0, a_valid}, 32'h0);
    chk("afree_b_valid", {31'h0, b_valid}, 32'h1);

    // Release B: full channel refuses word 3 while popping 1
    in_sel = 1'b0; in_data = 32'h3; in_valid = 1'b1; b_ready = 1'b1; #1;
    chk("rel_full_refuse", {31'h0, in_ready}, 32'h0);
    chk("rel_b_data1", b_data, 32'h1);
    tick();
    chk("rel_b_data2", b_data, 32'h2);
    chk("rel_ready_again", {31'h0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    chk("rel_b_data3", b_data, 32'h3);
    chk("rel_b_valid3", {31'h0, b_valid}, 32'h1);
    tick();
    chk("rel_b_empty", {31'h0, b_valid}, 32'h0);

    // Alternating select, both consumers ready
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sel = (i % 2 == 0); in_data = i; in_valid = 1'b1; #1;
      chk($sformatf("alt_ready_%0d", i), {31'h0, in_ready}, 32'h1);
      tick();
      if (i % 2 == 0) begin
        chk($sformatf("alt_a_data_%0d", i), a_data, i);
        chk($sformatf("alt_b_valid_%0d", i), {31'h0, b_valid}, 32'h0);
      end else begin
        chk($sformatf("alt_b_data_%0d", i), b_data, i);
        chk($sformatf("alt_a_valid_%0d", i), {31'h0, a_valid}, 32'h0);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("alt_a_idle", {31'h0, a_valid}, 32'h0);
    chk("alt_b_idle", {31'h0, b_valid}, 32'h0);

    // Reset discards buffered words
    a_ready = 1'b0; in_sel = 1'b1; in_valid = 1'b1;
    in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_valid = 1'b0; #1;
    chk("flush_a_full", {31'h0, in_ready}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("flush_a_valid", {31'h0, a_valid}, 32'h0);
    chk("flush_b_valid", {31'h0, b_valid}, 32'h0);
    chk("flush_a_data", a_data, 32'h0);
    chk("flush_in_ready", {31'h0, in_ready}, 32'h1);
    a_ready = 1'b1;
    tick();
    chk("flush_no_emit", {31'h0, a_valid}, 32'h0);

`ifdef DEMUX_STATS_EN
    begin
      int ready_drops;
      ready_drops = 0;
      chk("cnt_a_reset", {16'h0, a_count}, 32'h0);
      chk("cnt_b_reset", {16'h0, b_count}, 32'h0);
      in_sel = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 65534; i++) begin
        in_data = i;
        if (!in_ready) ready_drops++;
        tick();
      end
      in_valid = 1'b0;
      tick();
      chk("cnt_stream_ready", ready_drops, 32'h0);
      chk("cnt_a_fffe", {16'h0, a_count}, 32'h0000FFFE);
      for (int k = 0; k < 3; k++) begin
        in_valid = 1'b1; in_data = 32'hC0 + k;
        tick();
        in_valid = 1'b0;
        tick();
        case (k)
          0: chk("cnt_a_ffff", {16'h0, a_count}, 32'h0000FFFF);
          1: chk("cnt_a_wrap", {16'h0, a_count}, 32'h00000000);
          default: chk("cnt_a_0001", {16'h0, a_count}, 32'h00000001);
        endcase
        chk($sformatf("cnt_b_zero_%0d", k), {16'h0, b_count}, 32'h0);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
